// File: rtl/multiplicador_sequencial_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// datapath width, number of add/shift cycles and controller state encoding.
package multiplicador_sequencial_pkg;

  localparam int LARGURA = 8;
  localparam int CICLOS  = 8;

  // Counter value on the last add/shift cycle.
  localparam logic [2:0] ULTIMO = 3'(CICLOS - 1);

  // Encoding 2'd3 is unused; the next-state logic sends it back to OCIOSO.
  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    SOMA   = 2'd1,
    FIM    = 2'd2
  } estado_t;

endpackage

// File: rtl/somador_e_subtrator.sv
// 8-bit ripple-carry adder/subtractor from the ALU; s[8] is the carry-out
// (for subtraction it is the inverted borrow).
module somador_e_subtrator
  import multiplicador_sequencial_pkg::*;
(
  input  logic [LARGURA-1:0] a,
  input  logic [LARGURA-1:0] b,
  input  logic               sub,
  output logic [LARGURA:0]   s
);

  always_comb begin
    logic               carry;
    logic [LARGURA-1:0] bx;
    bx    = b ^ {LARGURA{sub}};
    carry = sub;
    s     = '0;
    for (int i = 0; i < LARGURA; i++) begin
      s[i]  = a[i] ^ bx[i] ^ carry;
      carry = (a[i] & bx[i]) | (carry & (a[i] ^ bx[i]));
    end
    s[LARGURA] = carry;
  end

endmodule

// File: rtl/multiplicador_sequencial.sv
// Unsigned 8x8 shift-and-add multiplier that reuses the ALU ripple adder for
// eight cycles. Handshake: inicio is accepted only while ocupado=0; pronto is a
// one-cycle pulse, and p is valid from that cycle until the next completion.
module multiplicador_sequencial
  import multiplicador_sequencial_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inicio,
  input  logic [LARGURA-1:0]   a,
  input  logic [LARGURA-1:0]   b,
  output logic                 ocupado,
  output logic                 pronto,
  output logic [2*LARGURA-1:0] p
);

  estado_t            estado;
  estado_t            proximo;
  logic [LARGURA-1:0] mcand;
  logic [LARGURA-1:0] mq;
  // The carry bit of the accumulator is always zero after the shift, so only
  // the low 8 bits of the partial product are kept.
  logic [LARGURA-1:0] acc;
  logic [2:0]         cnt;
  logic [LARGURA-1:0] parcela;
  logic [LARGURA:0]   s;

  assign parcela = mq[0] ? mcand : '0;

  somador_e_subtrator u_somador (
    .a   (acc),
    .b   (parcela),
    .sub (1'b0),
    .s   (s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo = OCIOSO;
    case (estado)
      OCIOSO:  proximo = inicio ? SOMA : OCIOSO;
      SOMA:    proximo = (cnt == ULTIMO) ? FIM : SOMA;
      FIM:     proximo = OCIOSO;
      default: proximo = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado = (estado != OCIOSO);
    pronto  = (estado == FIM);
  end

  // Each SOMA edge shifts the 17-bit {sum, mq} right by one; the final edge
  // also publishes the full product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      mq    <= '0;
      acc   <= '0;
      cnt   <= '0;
      p     <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (inicio) begin
            mcand <= a;
            mq    <= b;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        SOMA: begin
          acc <= s[LARGURA:1];
          mq  <= {s[0], mq[LARGURA-1:1]};
          cnt <= cnt + 3'd1;
          if (cnt == ULTIMO) begin
            p <= {s, mq[LARGURA-1:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_sequencial.sv
// Bench for multiplicador_sequencial: directed corner cases plus random
// operands, compared against plain a*b products.
module tb_multiplicador_sequencial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inicio;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ocupado;
  logic        pronto;
  logic [15:0] p;

  logic [15:0] exp_q[$];
  logic [15:0] ultimo_p;
  int          n_checks = 0;
  int          n_errors = 0;

  multiplicador_sequencial dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inicio  (inicio),
    .a       (a),
    .b       (b),
    .ocupado (ocupado),
    .pronto  (pronto),
    .p       (p)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, expv, $time);
    end
  endtask

  // One operation from the accept edge E0 to the return to idle at E9.
  // With ruido set, inicio is pulsed with a=b=FF in SOMA cycle 3 and in FIM.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input bit ruido);
    logic [15:0] esperado;
    @(negedge clk);
    a = x; b = y; inicio = 1'b1;
    exp_q.push_back(16'(x) * 16'(y));
    @(negedge clk);
    esperado = 16'hxxxx;
    for (int k = 0; k <= 8; k++) begin
      check("ocupado", 16'(ocupado), 16'd1);
      check("pronto", 16'(pronto), 16'(k == 8));
      if (k == 8) begin
        esperado = exp_q.pop_front();
        check("produto", p, esperado);
      end
      if (ruido && (k == 3 || k == 8)) begin
        inicio = 1'b1; a = 8'hFF; b = 8'hFF;
      end else begin
        inicio = 1'b0; a = 8'($urandom); b = 8'($urandom);
      end
      @(negedge clk);
    end
    inicio = 1'b0;
    check("fim_ocupado", 16'(ocupado), 16'd0);
    check("fim_pronto", 16'(pronto), 16'd0);
    check("fim_p", p, esperado);
    ultimo_p = esperado;
    if (ruido) begin
      @(negedge clk);
      check("sem_reinicio", 16'(ocupado), 16'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; inicio = 1'b0; a = '0; b = '0;
    #12;
    check("reset_ocupado", 16'(ocupado), 16'd0);
    check("reset_pronto", 16'(pronto), 16'd0);
    check("reset_p", p, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic product and corner values
    run_op(8'd13, 8'd11, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0);
    run_op(8'h00, 8'hFF, 1'b0);
    run_op(8'h80, 8'h02, 1'b0);

    // busy protection
    run_op(8'd5, 8'd7, 1'b1);

    // back-to-back with inicio held high
    @(negedge clk);
    a = 8'd2; b = 8'd3; inicio = 1'b1;
    @(negedge clk);
    a = 8'd4; b = 8'd4;
    for (int k = 0; k <= 18; k++) begin
      check("b2b_ocupado", 16'(ocupado), 16'(k != 9));
      check("b2b_pronto", 16'(pronto), 16'(k == 8 || k == 18));
      if (k == 8)  check("b2b_p1", p, 16'd6);
      if (k == 18) begin
        check("b2b_p2", p, 16'd16);
        inicio = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_idle", 16'(ocupado), 16'd0);

    // reset in the middle of SOMA
    @(negedge clk);
    a = 8'd9; b = 8'd9; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_meio_ocupado", 16'(ocupado), 16'd0);
    check("rst_meio_pronto", 16'(pronto), 16'd0);
    check("rst_meio_p", p, 16'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_sem_pronto", 16'(pronto), 16'd0);
    end
    rst_n = 1'b1;
    run_op(8'd3, 8'd3, 1'b0);

    // hold after completion
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      check("hold_p", p, ultimo_p);
      check("hold_pronto", 16'(pronto), 16'd0);
      check("hold_ocupado", 16'(ocupado), 16'd0);
    end

    // random operands, occasionally with busy-time noise
    for (int i = 0; i < 30; i++) begin
      run_op(8'($urandom), 8'($urandom), $urandom_range(0, 3) == 0);
    end

    check("fila_vazia", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
